// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the switch debouncer and any other PIO input qualifiers.
// The state encodings live here so that neighbouring blocks can decode the state.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } state_e;

  // Width of the accepted-rising-edge counter presented to software.
  localparam int EDGE_COUNT_WIDTH = 8;

endpackage

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop metastability synchronizer for one asynchronous level input.
// It is reusable by any PIO input and resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic stage1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bouncing board switch into a clean registered level.
// It also produces registered edge strobes and a wrapping count of accepted presses.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sw_raw,
  input  logic                        clr_count,
  output logic                        sw_clean,
  output logic                        rise_pulse,
  output logic                        fall_pulse,
  output logic [EDGE_COUNT_WIDTH-1:0] edge_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sw_sync;
  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw_raw),
    .q       (sw_sync)
  );

  // A level is accepted only after DEBOUNCE_CYCLES+1 consecutive agreeing samples.
  // Any disagreeing sample during qualification returns to the previous stable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      sw_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sw_sync) begin
            state <= PEND_HI;
            cnt   <= '0;
          end
        end
        PEND_HI: begin
          if (!sw_sync) begin
            state <= STABLE_LO;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_HI;
            sw_clean   <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        STABLE_HI: begin
          if (!sw_sync) begin
            state <= PEND_LO;
            cnt   <= '0;
          end
        end
        PEND_LO: begin
          if (sw_sync) begin
            state <= STABLE_HI;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_LO;
            sw_clean   <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= STABLE_LO;
      endcase
    end
  end

  // A clear coinciding with a rise strobe keeps that press counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_count <= '0;
    end else if (clr_count) begin
      edge_count <= rise_pulse ? EDGE_COUNT_WIDTH'(1) : '0;
    end else if (rise_pulse) begin
      edge_count <= edge_count + EDGE_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4.
// The reference model tracks run lengths of synchronized samples, not FSM states.
module tb_switch_debounce;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_raw = 1'b0;
  logic       clr_count = 1'b0;
  logic       sw_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_count;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_WIDTH       (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .clr_count  (clr_count),
    .sw_clean   (sw_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic rise;
  } exp_t;

  exp_t expQ[$];
  int   cycle = 0;
  int   total = 0;
  int   passed = 0;

  // Reference model: a two-sample delay, the current clean level, and the run
  // length of samples that disagree with it.
  logic       mFf1 = 1'b0;
  logic       mFf2 = 1'b0;
  logic       mClean = 1'b0;
  logic       mRise = 1'b0;
  int         runLen = 0;
  logic [7:0] mCount = 8'd0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
  endtask

  task automatic modelReset();
    mFf1 = 1'b0;
    mFf2 = 1'b0;
    mClean = 1'b0;
    mRise = 1'b0;
    runLen = 0;
    mCount = 8'd0;
    expQ.delete();
  endtask

  task automatic modelStep(input logic raw, input logic clr);
    logic seen;
    seen = mFf2;
    mFf2 = mFf1;
    mFf1 = raw;
    if (clr) mCount = mRise ? 8'd1 : 8'd0;
    else if (mRise) mCount = mCount + 8'd1;
    mRise = 1'b0;
    if (seen != mClean) begin
      runLen++;
      if (runLen == DEB + 1) begin
        mClean = seen;
        runLen = 0;
        mRise = seen;
        expQ.push_back('{cyc: cycle + 1, rise: seen});
      end
    end else begin
      runLen = 0;
    end
  endtask

  task automatic applyStimulus(input logic raw, input logic clr);
    @(negedge clk);
    sw_raw = raw;
    clr_count = clr;
    modelStep(raw, clr);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_sw_clean", sw_clean, 0);
    checkOutput("reset_rise", rise_pulse, 0);
    checkOutput("reset_fall", fall_pulse, 0);
    checkOutput("reset_edge_count", edge_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelStep(sw_raw, clr_count);
  endtask

  task automatic press(input bit clrOnRise);
    for (int i = 0; i < 14; i++) applyStimulus(i < 7, clrOnRise && mRise);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cycle++;

  // Monitor: every cycle compare levels, and match each strobe against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checkOutput("sw_clean", sw_clean, mClean);
    checkOutput("edge_count", edge_count, mCount);
    checkOutput("pulse_exclusive", int'(rise_pulse & fall_pulse), 0);
    if (rise_pulse || fall_pulse) begin
      checkOutput("pulse_queued", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pulse_cycle", cycle, e.cyc);
        checkOutput("pulse_kind_rise", rise_pulse, e.rise);
      end
    end else if (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
      e = expQ.pop_front();
      checkOutput("missing_pulse", int'(rise_pulse | fall_pulse), 1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("init_sw_clean", sw_clean, 0);
    checkOutput("init_edge_count", edge_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelStep(sw_raw, clr_count);

    // Short bounce is rejected.
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    settle();
    checkOutput("bounce_clean", sw_clean, 0);
    checkOutput("bounce_count", edge_count, 0);

    // Held press is accepted.
    repeat (12) applyStimulus(1'b1, 1'b0);
    settle();
    checkOutput("press_clean", sw_clean, 1);
    checkOutput("press_count", edge_count, 1);

    // Held release is accepted without counting.
    repeat (12) applyStimulus(1'b0, 1'b0);
    settle();
    checkOutput("release_clean", sw_clean, 0);
    checkOutput("release_count", edge_count, 1);

    // Reset in the middle of qualification, switch stays high across release.
    repeat (5) applyStimulus(1'b1, 1'b0);
    doReset();
    repeat (12) applyStimulus(1'b1, 1'b0);
    settle();
    checkOutput("held_through_reset_clean", sw_clean, 1);
    checkOutput("held_through_reset_count", edge_count, 1);
    repeat (12) applyStimulus(1'b0, 1'b0);

    // Counter wrap and clear racing a rise strobe.
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (255) press(1'b0);
    settle();
    checkOutput("preset_255", edge_count, 255);
    press(1'b0);
    settle();
    checkOutput("wrap_to_0", edge_count, 0);
    press(1'b1);
    settle();
    checkOutput("clear_with_rise", edge_count, 1);

    // Random bouncing with occasional clears and resets.
    repeat (200) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) applyStimulus(lvl, $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 49) == 0) doReset();
    end
    repeat (16) applyStimulus(sw_raw, 1'b0);
    settle();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
